// File: rtl/csi_pkg.sv
// Shared CSI-2 definitions: data types, sequencer state encoding, header byte
// positions and the Hamming ECC parity masks.
package csi_pkg;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_LS       = 6'h02;
   localparam logic [5:0] DT_LE       = 6'h03;
   localparam logic [5:0] DT_RAW10    = 6'h2B;
   localparam logic [5:0] DT_LONG_MIN = 6'h10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_SKIP,
      ST_FOOTER
   } state_t;

   localparam logic [1:0] HDR_DI  = 2'd0;
   localparam logic [1:0] HDR_WCL = 2'd1;
   localparam logic [1:0] HDR_WCH = 2'd2;
   localparam logic [1:0] HDR_ECC = 2'd3;

   // Each parity bit covers the header bits set in its mask, data = {WC_H, WC_L, DI}.
   localparam logic [23:0] ECC_MASK [0:5] = '{
      24'hF12CB7, 24'hF2555B, 24'h749A6D,
      24'hB8E38E, 24'hDF03F0, 24'hEFFC00
   };

   function automatic logic wc_is_mod5(input logic [15:0] wc);
      return (wc % 16'd5) == 16'd0;
   endfunction

endpackage

// File: rtl/csi_hdr_ecc.sv
// Combinational 6-bit CSI-2 packet header ECC generator over {WC_H, WC_L, DI}.
module csi_hdr_ecc
   import csi_pkg::*;
(
   input  logic [23:0] data,
   output logic [5:0]  ecc
);

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_parity
         assign ecc[gi] = ^(data & ECC_MASK[gi]);
      end
   endgenerate

endmodule

// File: rtl/csi_packet_sequencer.sv
// CSI-2 packet sequencer: header parsing, frame/line tracking, RAW10 payload gating.
// Define CSI_ECC_CHECK_EN to drop packets whose header ECC does not match.
module csi_packet_sequencer #(
   parameter int          CNT_W        = 16,
   parameter logic [5:0]  DT_RAW10     = 6'h2B,
   parameter int          FOOTER_BYTES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic [1:0]       vc_sel_i,
   input  logic             sot_i,
   input  logic             eot_i,
   input  logic [7:0]       byte_i,
   input  logic             byte_valid_i,
   input  logic             clr_err_i,
   output logic [7:0]       pay_data_o,
   output logic             pay_valid_o,
   output logic             pay_first_o,
   output logic             pay_last_o,
   output logic             fs_pulse_o,
   output logic             fe_pulse_o,
   output logic             frame_active_o,
   output logic             line_active_o,
   output logic [CNT_W-1:0] line_count_o,
   output logic [CNT_W-1:0] frame_count_o,
   output logic             err_trunc_o,
   output logic             err_wc_o,
   output logic             err_ecc_o
);
   import csi_pkg::*;

   state_t      state_reg, state_next, norm_next;
   logic [1:0]  hdr_idx_reg;
   logic [7:0]  di_reg, wcl_reg, wch_reg;
   logic [15:0] wc_reg, cnt_reg;

   logic [15:0] wc_hdr;
   logic [5:0]  dt_hdr;
   logic        is_short, raw_hit, ecc_ok, cnt_last, foot_last;
   logic        hdr_done, trunc_set, short_act, fs_hit, fe_hit, fwd, fwd_last;
   logic        wc_set, ecc_set;

   assign wc_hdr    = {wch_reg, wcl_reg};
   assign dt_hdr    = di_reg[5:0];
   assign is_short  = dt_hdr < DT_LONG_MIN;
   assign raw_hit   = (dt_hdr == DT_RAW10) && (di_reg[7:6] == vc_sel_i) && ecc_ok;
   assign cnt_last  = cnt_reg == (wc_reg - 16'd1);
   assign foot_last = cnt_reg == 16'(FOOTER_BYTES - 1);

`ifdef CSI_ECC_CHECK_EN
   logic [5:0] ecc_calc;

   csi_hdr_ecc u_hdr_ecc (
      .data ({wch_reg, wcl_reg, di_reg}),
      .ecc  (ecc_calc)
   );

   assign ecc_ok = ecc_calc == byte_i[5:0];
`else
   assign ecc_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      norm_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (sot_i && enable_i) norm_next = ST_HDR;
         ST_HDR: begin
            if (byte_valid_i && hdr_idx_reg == HDR_ECC) begin
               if (is_short)              norm_next = ST_IDLE;
               else if (wc_hdr == 16'd0)  norm_next = ST_FOOTER;
               else if (raw_hit)          norm_next = ST_PAYLOAD;
               else                       norm_next = ST_SKIP;
            end
         end
         ST_PAYLOAD,
         ST_SKIP:    if (byte_valid_i && cnt_last)  norm_next = ST_FOOTER;
         ST_FOOTER:  if (byte_valid_i && foot_last) norm_next = ST_IDLE;
         default:    norm_next = ST_IDLE;
      endcase
      // A new SoT restarts header capture; EoT only ends a packet legally on its final byte.
      state_next = norm_next;
      if (state_reg != ST_IDLE) begin
         if (sot_i)                                 state_next = ST_HDR;
         else if (eot_i && norm_next != ST_IDLE)    state_next = ST_IDLE;
      end
   end

   always_comb begin
      trunc_set = (state_reg != ST_IDLE) && (sot_i || (eot_i && norm_next != ST_IDLE));
      hdr_done  = (state_reg == ST_HDR) && byte_valid_i && (hdr_idx_reg == HDR_ECC) && !sot_i;
      short_act = hdr_done && is_short && ecc_ok && (di_reg[7:6] == vc_sel_i) && !trunc_set;
      fs_hit    = short_act && (dt_hdr == DT_FS);
      fe_hit    = short_act && (dt_hdr == DT_FE) && frame_active_o;
      wc_set    = hdr_done && (dt_hdr == DT_RAW10) && !wc_is_mod5(wc_hdr);
      ecc_set   = hdr_done && !ecc_ok;
      fwd       = (state_reg == ST_PAYLOAD) && byte_valid_i && !sot_i;
      fwd_last  = fwd && cnt_last && !trunc_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_idx_reg <= '0;
         di_reg      <= '0;
         wcl_reg     <= '0;
         wch_reg     <= '0;
         wc_reg      <= '0;
         cnt_reg     <= '0;
      end else begin
         if (state_reg != ST_HDR || sot_i) hdr_idx_reg <= '0;
         else if (byte_valid_i)            hdr_idx_reg <= hdr_idx_reg + 2'd1;
         if (state_reg == ST_HDR && byte_valid_i && !sot_i) begin
            case (hdr_idx_reg)
               HDR_DI:  di_reg  <= byte_i;
               HDR_WCL: wcl_reg <= byte_i;
               HDR_WCH: wch_reg <= byte_i;
               default: ;
            endcase
         end
         if (hdr_done) wc_reg <= wc_hdr;
         if (state_next != state_reg)
            cnt_reg <= '0;
         else if (byte_valid_i && (state_reg == ST_PAYLOAD || state_reg == ST_SKIP ||
                                   state_reg == ST_FOOTER))
            cnt_reg <= cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pay_data_o     <= '0;
         pay_valid_o    <= 1'b0;
         pay_first_o    <= 1'b0;
         pay_last_o     <= 1'b0;
         fs_pulse_o     <= 1'b0;
         fe_pulse_o     <= 1'b0;
         frame_active_o <= 1'b0;
         line_active_o  <= 1'b0;
         line_count_o   <= '0;
         frame_count_o  <= '0;
         err_trunc_o    <= 1'b0;
         err_wc_o       <= 1'b0;
         err_ecc_o      <= 1'b0;
      end else begin
         if (fwd) pay_data_o <= byte_i;
         pay_valid_o <= fwd;
         pay_first_o <= fwd && (cnt_reg == 16'd0);
         pay_last_o  <= fwd_last;
         fs_pulse_o  <= fs_hit;
         fe_pulse_o  <= fe_hit;
         if (fs_hit)      frame_active_o <= 1'b1;
         else if (fe_hit) frame_active_o <= 1'b0;
         // Stays high across byte_valid gaps until the cycle after the last byte.
         if (fwd)                          line_active_o <= 1'b1;
         else if (state_reg != ST_PAYLOAD) line_active_o <= 1'b0;
         if (fs_hit)        line_count_o <= '0;
         else if (fwd_last) line_count_o <= line_count_o + 1'b1;
         if (fe_hit) frame_count_o <= frame_count_o + 1'b1;
         err_trunc_o <= trunc_set || (err_trunc_o && !clr_err_i);
         err_wc_o    <= wc_set    || (err_wc_o    && !clr_err_i);
         err_ecc_o   <= ecc_set   || (err_ecc_o   && !clr_err_i);
      end
   end

endmodule

// File: tb/tb_csi_packet_sequencer.sv
// Self-checking bench for csi_packet_sequencer; payload bytes go through a scoreboard queue.
module tb_csi_packet_sequencer;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n, enable_i, sot_i, eot_i, byte_valid_i, clr_err_i;
   logic [1:0]       vc_sel_i;
   logic [7:0]       byte_i;
   logic [7:0]       pay_data_o;
   logic             pay_valid_o, pay_first_o, pay_last_o, fs_pulse_o, fe_pulse_o;
   logic             frame_active_o, line_active_o, err_trunc_o, err_wc_o, err_ecc_o;
   logic [CNT_W-1:0] line_count_o, frame_count_o;

   always #5 clk = ~clk;

   csi_packet_sequencer #(.CNT_W(CNT_W), .DT_RAW10(6'h2B), .FOOTER_BYTES(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable_i       (enable_i),
      .vc_sel_i       (vc_sel_i),
      .sot_i          (sot_i),
      .eot_i          (eot_i),
      .byte_i         (byte_i),
      .byte_valid_i   (byte_valid_i),
      .clr_err_i      (clr_err_i),
      .pay_data_o     (pay_data_o),
      .pay_valid_o    (pay_valid_o),
      .pay_first_o    (pay_first_o),
      .pay_last_o     (pay_last_o),
      .fs_pulse_o     (fs_pulse_o),
      .fe_pulse_o     (fe_pulse_o),
      .frame_active_o (frame_active_o),
      .line_active_o  (line_active_o),
      .line_count_o   (line_count_o),
      .frame_count_o  (frame_count_o),
      .err_trunc_o    (err_trunc_o),
      .err_wc_o       (err_wc_o),
      .err_ecc_o      (err_ecc_o)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       first;
      logic       last;
   } pay_t;

   pay_t exp_q[$];
   int   n_checks = 0, n_errors = 0;
   int   fs_seen = 0, fe_seen = 0, pay_seen = 0;
   int   exp_fs = 0, exp_fe = 0, exp_pay = 0, exp_lines = 0, exp_frames = 0;
   bit   exp_frame_act = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Independent CSI-2 header ECC model.
   function automatic logic [5:0] ecc_of(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (fs_pulse_o) fs_seen++;
         if (fe_pulse_o) fe_seen++;
         if (pay_valid_o) begin
            pay_t e;
            pay_seen++;
            check("line_active_with_pay", 32'(line_active_o), 32'd1);
            if (exp_q.size() == 0) begin
               check("pay_unexpected_qsize", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("pay_data",  32'(pay_data_o),  32'(e.data));
               check("pay_first", 32'(pay_first_o), 32'(e.first));
               check("pay_last",  32'(pay_last_o),  32'(e.last));
            end
         end
      end
   end

   task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] b);
      @(negedge clk);
      sot_i        = s;
      eot_i        = e;
      byte_valid_i = v;
      byte_i       = b;
      clr_err_i    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic pulse_clr();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      clr_err_i = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Sends one packet; npay < wc truncates the payload and omits the footer.
   task automatic send_pkt(input logic [7:0] di, input int wc, input int npay, input bit do_eot,
                           input logic [5:0] ecc_flip, input bit clr_at_hdr, input int drop_en_at);
      logic [7:0]  hdr [4];
      logic [15:0] w;
      logic [7:0]  b;
      logic [5:0]  dt;
      bit          ecc_good, match;
      w      = 16'(wc);
      dt     = di[5:0];
      hdr[0] = di;
      hdr[1] = w[7:0];
      hdr[2] = w[15:8];
      hdr[3] = {2'b00, ecc_of({w, di}) ^ ecc_flip};
`ifdef CSI_ECC_CHECK_EN
      ecc_good = (ecc_flip == 6'd0);
`else
      ecc_good = 1'b1;
`endif
      match = enable_i && ecc_good && (di[7:6] == vc_sel_i);
      $display("pkt di=%02h wc=%0d sent=%0d eot=%0d ecc=%02h en=%0d", di, wc, npay, do_eot,
               hdr[3], enable_i);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      for (int h = 0; h < 4; h++) begin
         drive(1'b0, 1'b0, 1'b1, hdr[h]);
         if (h == 3 && clr_at_hdr) clr_err_i = 1'b1;
      end
      if (match && dt == 6'h00) begin
         exp_fs++;
         exp_frame_act = 1'b1;
         exp_lines = 0;
      end
      if (match && dt == 6'h01 && exp_frame_act) begin
         exp_fe++;
         exp_frame_act = 1'b0;
         exp_frames++;
      end
      if (dt >= 6'h10) begin
         for (int i = 0; i < npay; i++) begin
            if (i == 2) drive(1'b0, 1'b0, 1'b0, 8'h00);
            b = 8'(8'h11 * (i + 1));
            drive(1'b0, 1'b0, 1'b1, b);
            if (i == drop_en_at) enable_i = 1'b0;
            if (match && dt == 6'h2B) begin
               exp_q.push_back('{data: b, first: (i == 0), last: (i == wc - 1)});
               exp_pay++;
            end
         end
         if (npay == wc) begin
            drive(1'b0, 1'b0, 1'b1, 8'hAA);
            drive(1'b0, 1'b0, 1'b1, 8'hBB);
            if (match && dt == 6'h2B && wc > 0) exp_lines++;
         end
      end
      if (do_eot) drive(1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; enable_i = 1'b1; vc_sel_i = 2'd0; sot_i = 1'b0; eot_i = 1'b0;
      byte_i = 8'h00; byte_valid_i = 1'b0; clr_err_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pay_valid",    32'(pay_valid_o),    32'd0);
      check("rst_fs_pulse",     32'(fs_pulse_o),     32'd0);
      check("rst_frame_active", 32'(frame_active_o), 32'd0);
      check("rst_line_active",  32'(line_active_o),  32'd0);
      check("rst_line_count",   32'(line_count_o),   32'd0);
      check("rst_frame_count",  32'(frame_count_o),  32'd0);
      check("rst_errs", 32'({err_trunc_o, err_wc_o, err_ecc_o}), 32'd0);
      rst_n = 1'b1;
      idle(2);

      send_pkt(8'h00, 0, 0, 1, 6'd0, 0, -1);
      idle(2);
      check("fs_pulses",     32'(fs_seen),        32'(exp_fs));
      check("fs_frame_act",  32'(frame_active_o), 32'(exp_frame_act));
      check("fs_line_count", 32'(line_count_o),   32'(exp_lines));

      send_pkt(8'h2B, 5, 5, 1, 6'd0, 0, -1);
      idle(2);
      check("raw5_lines",    32'(line_count_o), 32'(exp_lines));
      check("raw5_errs",     32'({err_trunc_o, err_wc_o, err_ecc_o}), 32'd0);
      check("raw5_line_act", 32'(line_active_o), 32'd0);
      check("raw5_pay_cnt",  32'(pay_seen), 32'(exp_pay));

      send_pkt(8'h6B, 5, 5, 1, 6'd0, 0, -1);
      send_pkt(8'h12, 3, 3, 1, 6'd0, 0, -1);
      idle(2);
      check("vc1_lines",   32'(line_count_o), 32'(exp_lines));
      check("vc1_pay_cnt", 32'(pay_seen), 32'(exp_pay));
      check("vc1_errs",    32'({err_trunc_o, err_wc_o, err_ecc_o}), 32'd0);

      send_pkt(8'h2B, 10, 4, 1, 6'd0, 0, -1);
      idle(2);
      check("trunc_err",   32'(err_trunc_o),  32'd1);
      check("trunc_lines", 32'(line_count_o), 32'(exp_lines));
      check("trunc_qsize", 32'(exp_q.size()), 32'd0);
      pulse_clr();
      check("trunc_clr", 32'(err_trunc_o), 32'd0);

      send_pkt(8'h2B, 6, 6, 1, 6'd0, 0, -1);
      idle(2);
      check("wc6_err",   32'(err_wc_o),     32'd1);
      check("wc6_lines", 32'(line_count_o), 32'(exp_lines));
      send_pkt(8'h2B, 0, 0, 1, 6'd0, 0, -1);
      idle(2);
      check("wc0_lines",   32'(line_count_o), 32'(exp_lines));
      check("wc0_pay_cnt", 32'(pay_seen), 32'(exp_pay));
      check("wc0_trunc",   32'(err_trunc_o), 32'd0);
      pulse_clr();
      check("wc_clr", 32'(err_wc_o), 32'd0);

      send_pkt(8'h2B, 6, 6, 1, 6'd0, 1, -1);
      idle(2);
      check("clr_vs_set_wc", 32'(err_wc_o), 32'd1);
      pulse_clr();

      send_pkt(8'h2B, 5, 2, 0, 6'd0, 0, -1);
      send_pkt(8'h2B, 5, 5, 1, 6'd0, 0, -1);
      idle(2);
      check("sot_restart_trunc", 32'(err_trunc_o),  32'd1);
      check("sot_restart_lines", 32'(line_count_o), 32'(exp_lines));
      pulse_clr();

      send_pkt(8'h01, 0, 0, 1, 6'd0, 0, -1);
      idle(2);
      send_pkt(8'h01, 0, 0, 1, 6'd0, 0, -1);
      idle(2);
      check("fe_pulses",      32'(fe_seen),        32'(exp_fe));
      check("fe_frame_act",   32'(frame_active_o), 32'(exp_frame_act));
      check("fe_frame_count", 32'(frame_count_o),  32'(exp_frames));

      send_pkt(8'h2B, 5, 5, 1, 6'd0, 0, 1);
      send_pkt(8'h2B, 5, 5, 1, 6'd0, 0, -1);
      idle(2);
      check("en_drop_lines",   32'(line_count_o), 32'(exp_lines));
      check("en_drop_pay_cnt", 32'(pay_seen), 32'(exp_pay));
      check("en_drop_errs",    32'({err_trunc_o, err_wc_o, err_ecc_o}), 32'd0);
      enable_i = 1'b1;

      send_pkt(8'h00, 0, 0, 1, 6'd1, 0, -1);
      idle(2);
      check("ecc_fs_pulses", 32'(fs_seen),        32'(exp_fs));
      check("ecc_frame_act", 32'(frame_active_o), 32'(exp_frame_act));
      check("ecc_lines",     32'(line_count_o),   32'(exp_lines));
`ifdef CSI_ECC_CHECK_EN
      check("ecc_err", 32'(err_ecc_o), 32'd1);
`else
      check("ecc_err", 32'(err_ecc_o), 32'd0);
`endif

      vc_sel_i = 2'd1;
      send_pkt(8'h6B, 5, 5, 1, 6'd0, 0, -1);
      idle(3);
      check("vc1_sel_lines",  32'(line_count_o), 32'(exp_lines));
      check("final_pay_cnt",  32'(pay_seen), 32'(exp_pay));
      check("final_qsize",    32'(exp_q.size()), 32'd0);
      check("final_frames",   32'(frame_count_o), 32'(exp_frames));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
